// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Program-counter register and instruction-fetch sequencer for the
// single-cycle core. Holds the architectural PC, fetches the instruction at
// that PC over a request/grant/response handshake, presents it to the
// datapath, and loads the next PC when the datapath accepts. Also keeps a
// retired-instruction counter.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned npc on accept redirects pc to TRAP_VEC, captures
//               the offending npc in bad_npc and pulses misalign for one cycle.
//   undefined : npc is force-aligned (low two bits cleared); misalign and
//               bad_npc are tied to 0.
//
// Ports:
//   clk          in   core clock, rising edge
//   rst          in   asynchronous active-high reset
//   npc[31:0]    in   next PC, sampled on accept
//   pc[31:0]     out  current PC
//   imem_req     out  fetch request (registered-state decode)
//   imem_addr    out  fetch address, equal to pc
//   imem_gnt     in   memory accepted the request
//   imem_rvalid  in   read data valid
//   imem_rdata   in   read data
//   inst[31:0]   out  fetched instruction
//   inst_valid   out  inst is valid for pc (registered-state decode)
//   inst_ready   in   datapath consumes inst this cycle
//   instret      out  retired-instruction count (wraps)
//   misalign     out  one-cycle pulse after a misaligned accept
//   bad_npc      out  last misaligned npc captured

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instret,
    output logic        misalign,
    output logic [31:0] bad_npc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        capture;
    logic [31:0] pc_nxt;

    // Handshake qualifiers: each input only matters in its own state, so
    // stray pulses elsewhere are ignored by construction.
    assign accept  = (state == VALID) && inst_ready;
    assign capture = (state == WAIT) && imem_rvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     if (imem_gnt) state_nxt = WAIT;
            WAIT:    if (imem_rvalid) state_nxt = VALID;
            VALID:   if (inst_ready) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded straight from the state register: glitch-free.
    assign imem_req   = (state == REQ);
    assign inst_valid = (state == VALID);
    assign imem_addr  = pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;

    assign misaligned = |npc[1:0];
    assign pc_nxt     = misaligned ? TRAP_VEC : npc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign <= 1'b0;
            bad_npc  <= '0;
        end else begin
            misalign <= accept && misaligned;
            if (accept && misaligned) begin
                bad_npc <= npc;
            end
        end
    end
`else
    // Without the trap, the low two bits are simply dropped.
    assign pc_nxt   = npc & 32'hFFFF_FFFC;
    assign misalign = 1'b0;
    // TRAP_VEC has no effect in this build; masking it keeps bad_npc at 0
    // while both builds share one parameter list.
    assign bad_npc  = TRAP_VEC & 32'h0000_0000;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            inst    <= '0;
            instret <= '0;
        end else begin
            if (capture) begin
                inst <= imem_rdata;
            end
            // A trapping instruction still retires.
            if (accept) begin
                pc      <= pc_nxt;
                instret <= instret + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: table-driven npc vectors, directed
// multi-cycle sequences, and a randomized run against a transaction-level
// memory/datapath model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0010;

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instret;
    logic        misalign;
    logic [31:0] bad_npc;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(
        .RESET_PC(RESET_PC),
        .TRAP_VEC(TRAP_VEC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .npc        (npc),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .instret    (instret),
        .misalign   (misalign),
        .bad_npc    (bad_npc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] npc;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] bad;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference next-PC rule, expressed arithmetically.
    function automatic logic [31:0] model_pc(input logic [31:0] n);
`ifdef FETCH_MISALIGN_TRAP_EN
        return (n % 4 != 0) ? TRAP_VEC : n;
`else
        return n - (n % 4);
`endif
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"}, pc, RESET_PC);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_inst_valid"}, {31'h0, inst_valid}, 32'h0);
        chk({tag, "_imem_req"}, {31'h0, imem_req}, 32'h0);
        chk({tag, "_instret"}, instret, 32'h0);
        chk({tag, "_misalign"}, {31'h0, misalign}, 32'h0);
        chk({tag, "_bad_npc"}, bad_npc, 32'h0);
    endtask

    initial begin
        int          exp_ret;
        logic [31:0] rdata_v;
        logic        outstanding;
        logic        have;
        logic        just_reset;
        logic        exp_req;
        logic        exp_mis;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [31:0] exp_bad;
        logic [31:0] exp_cnt;
        int          accepts;

`ifdef FETCH_MISALIGN_TRAP_EN
        vecs[0] = '{32'h0000_0104, 32'h0000_0104, 1'b0, 32'h0000_0000};
        vecs[1] = '{32'h0000_0102, TRAP_VEC,      1'b1, 32'h0000_0102};
        vecs[2] = '{32'h0000_0200, 32'h0000_0200, 1'b0, 32'h0000_0102};
        vecs[3] = '{32'h0000_0203, TRAP_VEC,      1'b1, 32'h0000_0203};
        vecs[4] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0000_0203};
`else
        vecs[0] = '{32'h0000_0104, 32'h0000_0104, 1'b0, 32'h0000_0000};
        vecs[1] = '{32'h0000_0102, 32'h0000_0100, 1'b0, 32'h0000_0000};
        vecs[2] = '{32'h0000_0200, 32'h0000_0200, 1'b0, 32'h0000_0000};
        vecs[3] = '{32'h0000_0203, 32'h0000_0200, 1'b0, 32'h0000_0000};
        vecs[4] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000};
`endif

        rst         = 1'b1;
        npc         = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;

        // Reset state.
        step();
        step();
        check_reset_values("reset");
        rst = 1'b0;
        chk("idle_no_req", {31'h0, imem_req}, 32'h0);
        step();
        chk("first_req", {31'h0, imem_req}, 32'h1);

        // Zero-wait memory, inst_ready high, npc = pc + 4.
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        inst_ready  = 1'b1;
        begin
            int nval = 0;
            for (int i = 0; i < 9; i++) begin
                chk($sformatf("zw_valid_%0d", i), {31'h0, inst_valid}, {31'h0, (i % 3 == 2)});
                if (inst_valid) begin
                    chk($sformatf("zw_pc_%0d", nval), pc, 32'(nval * 4));
                    chk($sformatf("zw_inst_%0d", nval), inst, 32'h0000_0013);
                    nval++;
                end
                npc = pc + 32'd4;
                step();
            end
        end
        chk("zw_instret", instret, 32'd3);
        chk("zw_pc_after", pc, 32'd12);

        // Grant delayed 3 cycles, with a stray rvalid pulse during REQ.
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        inst_ready  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dly_req_%0d", i), {31'h0, imem_req}, 32'h1);
            chk($sformatf("dly_addr_%0d", i), imem_addr, 32'd12);
            if (i == 2) chk("spur_rvalid_inst", inst, 32'h0000_0013);
            imem_rvalid = (i == 1);
            imem_rdata  = (i == 1) ? 32'hDEAD_BEEF : 32'h0;
            imem_gnt    = (i == 3);
            step();
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        chk("wait_no_req", {31'h0, imem_req}, 32'h0);
        chk("wait_no_valid", {31'h0, inst_valid}, 32'h0);

        // Stray inst_ready pulse during WAIT.
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("spur_ready_req", {31'h0, imem_req}, 32'h0);
        chk("spur_ready_valid", {31'h0, inst_valid}, 32'h0);
        chk("spur_ready_pc", pc, 32'd12);
        chk("spur_ready_instret", instret, 32'd3);

        imem_rvalid = 1'b1;
        imem_rdata  = 32'hABCD_0001;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;

        // Datapath stalls for 5 cycles in VALID.
        npc = 32'h0000_0040;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_valid_%0d", i), {31'h0, inst_valid}, 32'h1);
            chk($sformatf("stall_inst_%0d", i), inst, 32'hABCD_0001);
            chk($sformatf("stall_pc_%0d", i), pc, 32'd12);
            chk($sformatf("stall_instret_%0d", i), instret, 32'd3);
            step();
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("stall_acc_pc", pc, 32'h0000_0040);
        chk("stall_acc_instret", instret, 32'd4);
        chk("stall_acc_req", {31'h0, imem_req}, 32'h1);
        exp_ret = 4;

        // npc alignment / trap vectors.
        for (int v = 0; v < 5; v++) begin
            rdata_v  = $urandom;
            imem_gnt = 1'b1;
            step();
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b1;
            imem_rdata  = rdata_v;
            step();
            imem_rvalid = 1'b0;
            chk($sformatf("vec%0d_inst", v), inst, rdata_v);
            inst_ready = 1'b1;
            npc        = vecs[v].npc;
            step();
            inst_ready = 1'b0;
            exp_ret++;
            chk($sformatf("vec%0d_pc", v), pc, vecs[v].pc);
            chk($sformatf("vec%0d_misalign", v), {31'h0, misalign}, {31'h0, vecs[v].mis});
            chk($sformatf("vec%0d_bad_npc", v), bad_npc, vecs[v].bad);
            chk($sformatf("vec%0d_instret", v), instret, 32'(exp_ret));
            step();
            chk($sformatf("vec%0d_misalign_end", v), {31'h0, misalign}, 32'h0);
        end

        // Reset asserted while a fetch is in flight (WAIT).
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        step();
        step();
        rst = 1'b0;
        chk("rst_idle_no_req", {31'h0, imem_req}, 32'h0);
        step();
        chk("rst_req", {31'h0, imem_req}, 32'h1);
        chk("rst_addr", imem_addr, RESET_PC);

        // instret wrap: preload the counter just below wrap, then accept.
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        step();
        imem_rvalid = 1'b0;
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        #1;
        inst_ready = 1'b1;
        npc        = 32'h0000_0004;
        step();
        inst_ready = 1'b0;
        chk("wrap_instret", instret, 32'h0);
        chk("wrap_pc", pc, 32'h0000_0004);

        // Randomized run against the transaction-level model.
        rst = 1'b1;
        step();
        step();
        rst         = 1'b0;
        outstanding = 1'b0;
        have        = 1'b0;
        just_reset  = 1'b1;
        exp_pc      = RESET_PC;
        exp_inst    = '0;
        exp_bad     = '0;
        exp_mis     = 1'b0;
        exp_cnt     = '0;
        accepts     = 0;
        for (int c = 0; c < 3000; c++) begin
            exp_req = !outstanding && !have && !just_reset;
            chk("rnd_valid", {31'h0, inst_valid}, {31'h0, have});
            chk("rnd_req", {31'h0, imem_req}, {31'h0, exp_req});
            chk("rnd_pc", pc, exp_pc);
            chk("rnd_instret", instret, exp_cnt);
            chk("rnd_misalign", {31'h0, misalign}, {31'h0, exp_mis});
            chk("rnd_bad_npc", bad_npc, exp_bad);
            if (exp_req) chk("rnd_addr", imem_addr, exp_pc);
            if (have) chk("rnd_inst", inst, exp_inst);

            imem_gnt    = ($urandom_range(0, 2) == 0);
            imem_rvalid = outstanding ? ($urandom_range(0, 1) == 1)
                                      : ($urandom_range(0, 9) == 0);
            imem_rdata  = $urandom;
            inst_ready  = ($urandom_range(0, 1) == 1);
            npc         = $urandom;
            if ($urandom_range(0, 3) != 0) npc = npc - (npc % 4);

            exp_mis = 1'b0;
            if (exp_req && imem_gnt) begin
                outstanding = 1'b1;
            end else if (outstanding && imem_rvalid) begin
                outstanding = 1'b0;
                have        = 1'b1;
                exp_inst    = imem_rdata;
            end else if (have && inst_ready) begin
                have    = 1'b0;
                exp_cnt = exp_cnt + 32'd1;
                exp_pc  = model_pc(npc);
                accepts++;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (npc % 4 != 0) begin
                    exp_mis = 1'b1;
                    exp_bad = npc;
                end
`endif
            end
            just_reset = 1'b0;
            step();
        end
        chk("rnd_progress", {31'h0, (accepts > 100)}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
